ring_seq_ctrl: RTL and testbench
================================

Name: ring_seq_ctrl

Overview:
Controller and sequencer for an N-stage one-hot ring counter. It loads a seed pattern, runs the token around the ring for a programmed number of laps, and supports pause and single-step. It counts completed laps, flags invalid or corrupted patterns, and recovers from them. It sits between system control logic and the ring stages, and replaces ad-hoc per-stage preset/clear sequencing with one clean start/stop interface.

Parameters:
N, 4, number of ring stages (N >= 2)
LAPW, 8, width of the lap target and lap counter

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous reset, active-high
START  input  1  load SEED/LAPS and run; also resumes from PAUSE
STOP  input  1  pause when running; abort to IDLE when paused
STEP  input  1  single rotation while in PAUSE
SEED  input  N  initial ring pattern, must be one-hot
LAPS  input  LAPW  lap target; 0 means run forever
Q  output  N  ring state; Q[0] is the first stage
BUSY  output  1  high in RUN and PAUSE
DONE  output  1  high in DONE state
LAP_CNT  output  LAPW  completed laps since last START
ERR  output  1  sticky error flag

Behaviour:
- Interface:
  - One clock, CLK.
  - Reset RST is synchronous and active-high.
  - All outputs are registered.
- Reset (RST=1 at a CLK edge): state=IDLE, Q=0, BUSY=0, DONE=0, LAP_CNT=0, ERR=0. RST overrides every other input, including mid-run.
- Rotation: Q[i] <= Q[i-1] for i>0; Q[0] <= Q[N-1]. The token moves toward higher index.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority per cycle: STOP > START > STEP.
- IDLE:
  - START: latch SEED into seed_r and LAPS into laps_r; Q <= seed_r; LAP_CNT <= 0; ERR <= 0; go to RUN.
  - Q equals the seed on the edge after START is sampled. The first rotation happens on the following edge.
  - Invalid seed (zero, or more than one bit set): Q <= 1 (bit 0 only), seed_r <= 1, ERR <= 1; still go to RUN.
- RUN:
  - Rotate every cycle.
  - When the rotated value equals seed_r, LAP_CNT increments on that edge.
  - If laps_r != 0 and the incremented LAP_CNT == laps_r, go to DONE on the same edge. Q holds that final value (equal to seed_r).
  - If laps_r == 0, LAP_CNT wraps from 2^LAPW-1 to 0 and the block never enters DONE.
  - STOP: go to PAUSE with no rotation on that edge.
- PAUSE:
  - Q and LAP_CNT hold.
  - STEP: one rotation, with the same lap counting and DONE check as RUN; stay in PAUSE unless DONE is reached.
  - START: resume RUN without reloading. Rotation resumes on the next edge.
  - STOP: go to IDLE with Q <= 0. LAP_CNT holds.
- DONE:
  - Q and LAP_CNT hold; DONE=1.
  - START: full reload as in IDLE.
  - STOP: go to IDLE with Q <= 0.
- Corruption check (RUN and PAUSE):
  - If Q is not one-hot, the next edge reloads Q <= seed_r and sets ERR <= 1.
  - No rotation and no lap count on that edge.
- ERR is cleared only by RST or by a START that carries a valid seed.
- BUSY = (state==RUN or state==PAUSE). DONE = (state==DONE).
- STEP in IDLE, RUN or DONE is ignored. START in RUN is ignored (no restart).

Test Plan:
1. N=4, SEED=0001, LAPS=2, START pulse at edge 0 -> Q=0001@e1, 0010@e2, 0100@e3, 1000@e4, 0001@e5 with LAP_CNT=1, 0001@e9 with LAP_CNT=2, DONE=1, BUSY=0; Q holds 0001 thereafter.
2. Run with SEED=0100, LAPS=0; STOP at Q=0001 -> Q holds 0001 and BUSY=1. Three STEP pulses -> 0010, 0100 (LAP_CNT+1), 1000. START -> rotation resumes next edge. STOP twice -> IDLE with Q=0000.
3. START with SEED=0110 -> Q=0001 and ERR=1 on the next edge; ring runs normally. A later START with SEED=1000 -> ERR=0 and Q=1000.
4. LAPS=0, SEED=0001, run 1024 rotations -> LAP_CNT wraps 255->0 at lap 256 and DONE never asserts.
5. Assert RST mid-RUN with Q=0100 -> on the next edge Q=0000, LAP_CNT=0, BUSY=0, state IDLE. STOP, START and STEP asserted in the same cycle as RST have no effect.
6. STOP and START asserted together in RUN -> PAUSE (STOP wins). STOP and STEP together in PAUSE -> IDLE, Q=0000.

Source files
------------

// File: rtl/ring_seq_ctrl_if.sv
// Control and status bundle between system logic (master) and the ring sequencer (slave).
interface ring_seq_ctrl_if #(
  parameter int unsigned N    = 4,
  parameter int unsigned LAPW = 8
);
  logic            START;
  logic            STOP;
  logic            STEP;
  logic [N-1:0]    SEED;
  logic [LAPW-1:0] LAPS;
  logic [N-1:0]    Q;
  logic            BUSY;
  logic            DONE;
  logic [LAPW-1:0] LAP_CNT;
  logic            ERR;

  modport master (
    output START, STOP, STEP, SEED, LAPS,
    input  Q, BUSY, DONE, LAP_CNT, ERR
  );

  modport slave (
    input  START, STOP, STEP, SEED, LAPS,
    output Q, BUSY, DONE, LAP_CNT, ERR
  );
endinterface

// File: rtl/ring_seq_ctrl.sv
// One-hot ring counter sequencer: seed load, lap-limited run, pause/single-step,
// lap counting and recovery from invalid or corrupted ring patterns.
module ring_seq_ctrl #(
  parameter int unsigned N    = 4,
  parameter int unsigned LAPW = 8
) (
  input logic             CLK,
  input logic             RST,
  ring_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;
  typedef enum logic [2:0] {ActHold, ActLoad, ActAdv, ActFix, ActClear} action_e;

  localparam logic [N-1:0]    OneHot0 = {{(N-1){1'b0}}, 1'b1};
  localparam logic [LAPW-1:0] LapOne  = {{(LAPW-1){1'b0}}, 1'b1};

  function automatic logic is_onehot(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - OneHot0)) == '0);
  endfunction

  state_e          state_q, state_d;
  action_e         act;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    seed_q, seed_d;
  logic [LAPW-1:0] laps_q, laps_d;
  logic [LAPW-1:0] lap_cnt_q, lap_cnt_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            seed_ok;
  logic [N-1:0]    seed_eff;
  logic [N-1:0]    rot;
  logic [LAPW-1:0] lap_inc;
  logic            lap_hit;
  logic            done_hit;
  logic            q_ok;

  assign seed_ok  = is_onehot(bus.SEED);
  assign seed_eff = seed_ok ? bus.SEED : OneHot0;
  assign rot      = {q_q[N-2:0], q_q[N-1]};
  assign lap_inc  = lap_cnt_q + LapOne;
  assign lap_hit  = (rot == seed_q);
  // A zero lap target never matches, so the ring runs forever and the count wraps.
  assign done_hit = lap_hit && (laps_q != '0) && (lap_inc == laps_q);
  assign q_ok     = is_onehot(q_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      q_q       <= '0;
      seed_q    <= '0;
      laps_q    <= '0;
      lap_cnt_q <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      seed_q    <= seed_d;
      laps_q    <= laps_d;
      lap_cnt_q <= lap_cnt_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next state and the datapath action for this edge; STOP > START > STEP.
  always_comb begin
    state_d = state_q;
    act     = ActHold;
    unique case (state_q)
      StIdle: begin
        if (!bus.STOP && bus.START) begin
          act     = ActLoad;
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.STOP) begin
          state_d = StPause;
        end else if (!q_ok) begin
          act = ActFix;
        end else begin
          act = ActAdv;
          if (done_hit) state_d = StDone;
        end
      end
      StPause: begin
        if (bus.STOP) begin
          act     = ActClear;
          state_d = StIdle;
        end else if (!q_ok) begin
          act = ActFix;
        end else if (bus.START) begin
          state_d = StRun;
        end else if (bus.STEP) begin
          act = ActAdv;
          if (done_hit) state_d = StDone;
        end
      end
      StDone: begin
        if (bus.STOP) begin
          act     = ActClear;
          state_d = StIdle;
        end else if (bus.START) begin
          act     = ActLoad;
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    q_d       = q_q;
    seed_d    = seed_q;
    laps_d    = laps_q;
    lap_cnt_d = lap_cnt_q;
    err_d     = err_q;
    unique case (act)
      ActLoad: begin
        seed_d    = seed_eff;
        laps_d    = bus.LAPS;
        q_d       = seed_eff;
        lap_cnt_d = '0;
        err_d     = !seed_ok;
      end
      ActAdv: begin
        q_d = rot;
        if (lap_hit) lap_cnt_d = lap_inc;
      end
      ActFix: begin
        q_d   = seed_q;
        err_d = 1'b1;
      end
      ActClear: q_d = '0;
      default: ;
    endcase
    busy_d = (state_d == StRun) || (state_d == StPause);
    done_d = (state_d == StDone);
  end

  assign bus.Q       = q_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.LAP_CNT = lap_cnt_q;
  assign bus.ERR     = err_q;

endmodule

// File: tb/tb_ring_seq_ctrl.sv
// Directed bench for ring_seq_ctrl: stimulus pushes expected outputs into a queue,
// a monitor pops and compares one entry per cycle on the falling edge.
module tb_ring_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ring_seq_ctrl_if #(.N(4), .LAPW(8)) bus ();

  ring_seq_ctrl #(.N(4), .LAPW(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic [7:0] lap;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  initial begin
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
    bus.STEP  = 1'b0;
    bus.SEED  = '0;
    bus.LAPS  = '0;
  end

  // Monitor: outputs settle after the rising edge, compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_chk++;
        if ({bus.Q, bus.BUSY, bus.DONE, bus.LAP_CNT, bus.ERR} !==
            {e.q, e.busy, e.done, e.lap, e.err}) begin
          n_fail++;
          $display("FAIL %s: got Q=%b BUSY=%b DONE=%b LAP_CNT=%0d ERR=%b, expected Q=%b BUSY=%b DONE=%b LAP_CNT=%0d ERR=%b",
                   e.name, bus.Q, bus.BUSY, bus.DONE, bus.LAP_CNT, bus.ERR,
                   e.q, e.busy, e.done, e.lap, e.err);
        end
      end
    end
  end

  task automatic cyc(input string name, input bit rs, input bit st, input bit sp, input bit stp,
                     input logic [3:0] sd, input logic [7:0] lp, input bit chk,
                     input logic [3:0] eq, input bit eb, input bit ed, input logic [7:0] el,
                     input bit ee);
    exp_t e;
    @(negedge clk);
    rst       = rs;
    bus.START = st;
    bus.STOP  = sp;
    bus.STEP  = stp;
    bus.SEED  = sd;
    bus.LAPS  = lp;
    @(posedge clk);
    #1;
    if (chk) begin
      e.name = name;
      e.q    = eq;
      e.busy = eb;
      e.done = ed;
      e.lap  = el;
      e.err  = ee;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input string name, input logic [3:0] eq, input bit eb, input bit ed,
                      input logic [7:0] el, input bit ee);
    cyc(name, 0, 0, 0, 0, 4'b0000, 8'd0, 1, eq, eb, ed, el, ee);
  endtask

  initial begin
    // Reset
    cyc("reset0", 1, 0, 0, 0, 4'b0000, 8'd0, 1, 4'b0000, 0, 0, 8'd0, 0);
    cyc("reset1", 1, 1, 0, 0, 4'b0001, 8'd1, 1, 4'b0000, 0, 0, 8'd0, 0);

    // 1: two laps from 0001, then DONE hold, reload from DONE with LAPS=1
    cyc("t1_load", 0, 1, 0, 0, 4'b0001, 8'd2, 1, 4'b0001, 1, 0, 8'd0, 0);
    idle("t1_e2", 4'b0010, 1, 0, 8'd0, 0);
    idle("t1_e3", 4'b0100, 1, 0, 8'd0, 0);
    idle("t1_e4", 4'b1000, 1, 0, 8'd0, 0);
    idle("t1_e5_lap1", 4'b0001, 1, 0, 8'd1, 0);
    idle("t1_e6", 4'b0010, 1, 0, 8'd1, 0);
    idle("t1_e7", 4'b0100, 1, 0, 8'd1, 0);
    idle("t1_e8", 4'b1000, 1, 0, 8'd1, 0);
    idle("t1_e9_done", 4'b0001, 0, 1, 8'd2, 0);
    idle("t1_done_hold", 4'b0001, 0, 1, 8'd2, 0);
    cyc("t1_reload", 0, 1, 0, 0, 4'b0010, 8'd1, 1, 4'b0010, 1, 0, 8'd0, 0);
    idle("t1r_1", 4'b0100, 1, 0, 8'd0, 0);
    idle("t1r_2", 4'b1000, 1, 0, 8'd0, 0);
    idle("t1r_3", 4'b0001, 1, 0, 8'd0, 0);
    idle("t1r_done", 4'b0010, 0, 1, 8'd1, 0);
    cyc("t1_step_in_done", 0, 0, 0, 1, 4'b0000, 8'd0, 1, 4'b0010, 0, 1, 8'd1, 0);
    cyc("t1_stop_done", 0, 0, 1, 0, 4'b0000, 8'd0, 1, 4'b0000, 0, 0, 8'd1, 0);

    // 2: pause, single-step, resume, abort
    cyc("t2_load", 0, 1, 0, 0, 4'b0100, 8'd0, 1, 4'b0100, 1, 0, 8'd0, 0);
    idle("t2_r1", 4'b1000, 1, 0, 8'd0, 0);
    idle("t2_r2", 4'b0001, 1, 0, 8'd0, 0);
    cyc("t2_pause", 0, 0, 1, 0, 4'b0000, 8'd0, 1, 4'b0001, 1, 0, 8'd0, 0);
    idle("t2_pause_hold", 4'b0001, 1, 0, 8'd0, 0);
    cyc("t2_step1", 0, 0, 0, 1, 4'b0000, 8'd0, 1, 4'b0010, 1, 0, 8'd0, 0);
    cyc("t2_step2_lap", 0, 0, 0, 1, 4'b0000, 8'd0, 1, 4'b0100, 1, 0, 8'd1, 0);
    cyc("t2_step3", 0, 0, 0, 1, 4'b0000, 8'd0, 1, 4'b1000, 1, 0, 8'd1, 0);
    cyc("t2_resume", 0, 1, 0, 0, 4'b0001, 8'd9, 1, 4'b1000, 1, 0, 8'd1, 0);
    idle("t2_resumed_rot", 4'b0001, 1, 0, 8'd1, 0);
    cyc("t2_stop1", 0, 0, 1, 0, 4'b0000, 8'd0, 1, 4'b0001, 1, 0, 8'd1, 0);
    cyc("t2_stop2_idle", 0, 0, 1, 0, 4'b0000, 8'd0, 1, 4'b0000, 0, 0, 8'd1, 0);
    cyc("t2_step_in_idle", 0, 0, 0, 1, 4'b0000, 8'd0, 1, 4'b0000, 0, 0, 8'd1, 0);

    // 3: invalid seed, START ignored in RUN, sticky ERR, valid reload clears it
    cyc("t3_bad_seed", 0, 1, 0, 0, 4'b0110, 8'd0, 1, 4'b0001, 1, 0, 8'd0, 1);
    idle("t3_r1", 4'b0010, 1, 0, 8'd0, 1);
    idle("t3_r2", 4'b0100, 1, 0, 8'd0, 1);
    idle("t3_r3", 4'b1000, 1, 0, 8'd0, 1);
    idle("t3_r4_lap", 4'b0001, 1, 0, 8'd1, 1);
    cyc("t3_start_in_run", 0, 1, 0, 0, 4'b1000, 8'd3, 1, 4'b0010, 1, 0, 8'd1, 1);
    cyc("t3_stop1", 0, 0, 1, 0, 4'b0000, 8'd0, 1, 4'b0010, 1, 0, 8'd1, 1);
    cyc("t3_stop2", 0, 0, 1, 0, 4'b0000, 8'd0, 1, 4'b0000, 0, 0, 8'd1, 1);
    cyc("t3_good_seed", 0, 1, 0, 0, 4'b1000, 8'd3, 1, 4'b1000, 1, 0, 8'd0, 0);

    // 6: STOP beats START in RUN, STOP beats STEP in PAUSE
    cyc("t6_stop_start", 0, 1, 1, 0, 4'b0001, 8'd0, 1, 4'b1000, 1, 0, 8'd0, 0);
    idle("t6_paused", 4'b1000, 1, 0, 8'd0, 0);
    cyc("t6_stop_step", 0, 0, 1, 1, 4'b0000, 8'd0, 1, 4'b0000, 0, 0, 8'd0, 0);

    // 4: LAPS=0 free run, lap counter wraps at 256 laps, DONE never asserts
    cyc("t4_load", 0, 1, 0, 0, 4'b0001, 8'd0, 1, 4'b0001, 1, 0, 8'd0, 0);
    for (int k = 1; k <= 1024; k++) begin
      if (k == 2)         idle("t4_k2", 4'b0100, 1, 0, 8'd0, 0);
      else if (k == 4)    idle("t4_k4", 4'b0001, 1, 0, 8'd1, 0);
      else if (k == 1020) idle("t4_k1020", 4'b0001, 1, 0, 8'd255, 0);
      else if (k == 1023) idle("t4_k1023", 4'b1000, 1, 0, 8'd255, 0);
      else if (k == 1024) idle("t4_wrap", 4'b0001, 1, 0, 8'd0, 0);
      else cyc("t4_run", 0, 0, 0, 0, 4'b0000, 8'd0, 0, 4'b0000, 0, 0, 8'd0, 0);
    end
    cyc("t4_stop1", 0, 0, 1, 0, 4'b0000, 8'd0, 1, 4'b0001, 1, 0, 8'd0, 0);
    cyc("t4_stop2", 0, 0, 1, 0, 4'b0000, 8'd0, 1, 4'b0000, 0, 0, 8'd0, 0);

    // 5: zero seed sets ERR, then RST mid-run overrides all inputs
    cyc("t5_zero_seed", 0, 1, 0, 0, 4'b0000, 8'd5, 1, 4'b0001, 1, 0, 8'd0, 1);
    idle("t5_r1", 4'b0010, 1, 0, 8'd0, 1);
    idle("t5_r2", 4'b0100, 1, 0, 8'd0, 1);
    cyc("t5_rst_all", 1, 1, 1, 1, 4'b1000, 8'd2, 1, 4'b0000, 0, 0, 8'd0, 0);
    idle("t5_after_rst", 4'b0000, 0, 0, 8'd0, 0);
    cyc("t5_step_idle", 0, 0, 0, 1, 4'b0000, 8'd0, 1, 4'b0000, 0, 0, 8'd0, 0);

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
